// File: rtl/kestrel2_pkg.sv
// Shared Kestrel-2 keyboard port definitions: bus address, status bit layout
// and the PS/2 frame helpers used by the receiver.
package kestrel2_pkg;

   localparam logic [15:0] KBD_ADDR      = 16'hFFFE;
   localparam int          KBD_VALID     = 15;
   localparam int          KBD_OVR       = 14;
   localparam int          KBD_ERR       = 13;
   localparam int          PS2_DATA_BITS = 8;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // PS/2 uses odd parity over data+parity and a stop bit of 1.
   function automatic logic frame_ok(input logic [7:0] data, input logic par,
                                     input logic stop);
      return stop & (^{data, par});
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deframer: pin synchronizers, clock glitch filter,
// bit-level FSM and a frame timeout that abandons stalled partial frames.
module ps2_frame_rx
   import kestrel2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ps2c_i,
   input  logic       ps2d_i,
   output logic [7:0] byte_o,
   output logic       byte_stb_o,
   output logic       err_stb_o
);

   localparam int FLT_W = $clog2(FILTER_LEN + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic             c_s1, c_s2, d_s1, d_s2;
   logic             c_filt, c_filt_d, fall;
   logic [FLT_W-1:0] flt_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;
   rx_state_t        state, state_nx;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic             par_q;
   logic             shift_en, frame_good, frame_bad;

   assign fall    = c_filt_d & ~c_filt;
   assign tmo_hit = (state != RX_IDLE) && !fall &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign byte_o  = shreg;

   always_comb begin
      state_nx   = state;
      shift_en   = 1'b0;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         RX_IDLE:   if (fall && !d_s2) state_nx = RX_DATA;
         RX_DATA:   if (fall) begin
                       shift_en = 1'b1;
                       if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_nx = RX_PARITY;
                    end
         RX_PARITY: if (fall) state_nx = RX_STOP;
         RX_STOP:   if (fall) begin
                       state_nx = RX_IDLE;
                       if (frame_ok(shreg, par_q, d_s2)) frame_good = 1'b1;
                       else                              frame_bad  = 1'b1;
                    end
         default:   state_nx = RX_IDLE;
      endcase
      if (tmo_hit) begin
         state_nx  = RX_IDLE;
         frame_bad = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         c_s1       <= 1'b1;
         c_s2       <= 1'b1;
         d_s1       <= 1'b1;
         d_s2       <= 1'b1;
         c_filt     <= 1'b1;
         c_filt_d   <= 1'b1;
         flt_cnt    <= '0;
         tmo_cnt    <= '0;
         state      <= RX_IDLE;
         bit_cnt    <= '0;
         byte_stb_o <= 1'b0;
         err_stb_o  <= 1'b0;
      end else begin
         c_s1     <= ps2c_i;
         c_s2     <= c_s1;
         d_s1     <= ps2d_i;
         d_s2     <= d_s1;
         c_filt_d <= c_filt;
         // A run of FILTER_LEN samples disagreeing with c_filt flips it.
         if (c_s2 == c_filt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
            c_filt  <= c_s2;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
         if (state == RX_IDLE || fall) tmo_cnt <= '0;
         else                          tmo_cnt <= tmo_cnt + 1'b1;
         state      <= state_nx;
         byte_stb_o <= frame_good;
         err_stb_o  <= frame_bad;
         if (state == RX_IDLE) bit_cnt <= '0;
         else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (shift_en) shreg <= {d_s2, shreg[7:1]};
      if (state == RX_PARITY && fall) par_q <= d_s2;
   end

endmodule

// File: rtl/kbd_ps2io.sv
// Kestrel-2 keyboard port: PS/2 receiver, byte FIFO, sticky overrun/error
// flags and a single-cycle-ack J1A data-bus responder.
module kbd_ps2io
   import kestrel2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int FIFO_AW        = 2
) (
   input  logic        sys_clk_i,
   input  logic        sys_rst_i,
   input  logic        ps2c_i,
   input  logic        ps2d_i,
   input  logic [15:0] dat_dat_i,
   output logic [15:0] dat_dat_o,
   input  logic        dat_we_i,
   input  logic        dat_cyc_i,
   input  logic        dat_stb_i,
   output logic        dat_ack_o
);

   localparam int DEPTH = 1 << FIFO_AW;

   logic [7:0]         rx_byte;
   logic               rx_stb, rx_err;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               ovr, err;
   logic               bus_go, rd_go, wr_go;
   logic               empty, full, pop, push, flush;
   logic [7:0]         head;
   logic               wr_unused;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk_i      (sys_clk_i),
      .rst_ni     (sys_rst_i),
      .ps2c_i     (ps2c_i),
      .ps2d_i     (ps2d_i),
      .byte_o     (rx_byte),
      .byte_stb_o (rx_stb),
      .err_stb_o  (rx_err)
   );

   // bus_go marks the edge at which ack rises; every side effect happens there.
   assign bus_go    = dat_cyc_i & dat_stb_i & ~dat_ack_o;
   assign rd_go     = bus_go & ~dat_we_i;
   assign wr_go     = bus_go & dat_we_i;
   assign wr_unused = ^dat_dat_i[12:0];

   assign empty = (count == '0);
   assign full  = (count == (FIFO_AW + 1)'(DEPTH));
   assign pop   = rd_go & ~empty;
   assign flush = wr_go & dat_dat_i[KBD_VALID];
   assign push  = rx_stb & ~flush & (~full | pop);
   assign head  = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         dat_ack_o <= 1'b0;
         dat_dat_o <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ovr       <= 1'b0;
         err       <= 1'b0;
      end else begin
         dat_ack_o <= bus_go;
         if (rd_go) dat_dat_o <= {~empty, ovr, err, 5'b0, head};
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
         end
         // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
         ovr <= (rx_stb & ~push & ~flush) | (ovr & ~(wr_go & dat_dat_i[KBD_OVR]));
         err <= rx_err | (err & ~(wr_go & dat_dat_i[KBD_ERR]));
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (push) mem[wr_ptr] <= rx_byte;
   end

endmodule

// File: doc/kbd_ps2io.md
Name: kbd_ps2io

Overview:
- PS/2 keyboard receiver and bus responder for the Kestrel-2 keyboard port at $FFFE.
- Samples the N2_PS2C_I and N2_PS2D_I pins, deframes 11-bit device-to-host frames and queues bytes in a small FIFO.
- Answers J1A data-bus read and write cycles with a registered single-cycle acknowledge.
- The top level drives dat_stb_i with data_access & (j1a_dat_adr_o == $FFFE) and ORs dat_ack_o into j1a_ack_i.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered PS/2 clock changes state.
- TIMEOUT_CYCLES, 5000: sys_clk cycles (200 us at 25 MHz) with no filtered clock edge before a partial frame is abandoned.
- FIFO_AW, 2: FIFO address width; depth is 2**FIFO_AW = 4 bytes.

Ports:
- sys_clk_i  in  1  system clock, 25 MHz from the MGIA.
- sys_rst_i  in  1  asynchronous reset, active-low; asserts asynchronously, deasserts synchronously to sys_clk_i.
- ps2c_i  in  1  raw PS/2 clock pin.
- ps2d_i  in  1  raw PS/2 data pin.
- dat_dat_i  in  16  write data.
- dat_dat_o  out  16  read data.
- dat_we_i  in  1  write enable.
- dat_cyc_i  in  1  bus cycle in progress.
- dat_stb_i  in  1  strobe, already address-qualified by the top level.
- dat_ack_o  out  1  acknowledge.

Behaviour:
- Reset: dat_ack_o=0, dat_dat_o=0, FIFO empty, ovr=0, err=0, receiver in IDLE, synchronizers=1, filter state=1, timeout counter=0.
- Input conditioning:
  - ps2c_i and ps2d_i each pass through a 2-FF synchronizer.
  - Filtered clock toggles only after FILTER_LEN equal samples.
  - A falling edge of the filtered clock samples the synchronized data bit.
- Receiver FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: a falling edge with data=0 goes to DATA with bit counter=0. A falling edge with data=1 stays in IDLE.
  - DATA: 8 edges shift data in LSB-first, then go to PARITY.
  - PARITY: store the parity bit, go to STOP.
  - STOP: on the edge, the frame is good if the stop bit is 1 and (data ^ parity) has odd parity.
    - Good frame: push the byte.
    - Bad frame: set err, no push.
    - Either way, return to IDLE.
  - Timeout: the counter clears on every filtered edge and counts while not in IDLE. At TIMEOUT_CYCLES it forces IDLE and sets err.
- FIFO:
  - Push while full: byte dropped, ovr set.
  - Push and pop in the same cycle with count>0: both take effect, count unchanged.
  - Pop while empty: no effect.
- Bus handshake:
  - dat_ack_o registers (dat_cyc_i & dat_stb_i & ~dat_ack_o), giving a pulse one cycle after strobe.
  - A strobe held high alternates ack; each ack is exactly one transaction.
  - All side effects occur in the ack cycle.
- Read format, registered and valid in the ack cycle: {valid, ovr, err, 5'b0, head byte}.
  - valid = FIFO non-empty.
  - When empty, the head byte reads as 0.
  - A read with valid=1 pops the head.
- Write:
  - dat_dat_i[14]=1 clears ovr.
  - dat_dat_i[13]=1 clears err.
  - dat_dat_i[15]=1 flushes the FIFO.
  - The write does not pop.
  - Set and clear of a flag in the same cycle: set wins.
- dat_dat_o holds its last value outside ack.
- Reset mid-frame: the partial byte is discarded; no push or err after release.

Decomposition:
- Shared package kestrel2_pkg holds:
  - KBD_ADDR = 16'hFFFE.
  - Status bit indices KBD_VALID=15, KBD_OVR=14, KBD_ERR=13.
  - PS2_DATA_BITS=8.
- Sub-module ps2_frame_rx contains the synchronizers, filter, FSM and timeout, with outputs byte_o[7:0], byte_stb_o and err_stb_o.
- kbd_ps2io holds the FIFO, flags and bus logic.

Test Plan:
- Frame 0x1C with parity 0 and stop 1, at a 40 us bit period; then two reads. Required: first read 0x801C, second 0x0000, each with one ack pulse.
- Frame 0x1C with parity 1. Required: no push; read returns 0x2000. Then write 0x2000; next read returns 0x0000.
- Five good frames 0x01 to 0x05, no reads in between. Required: reads return 0xC001, 0xC002, 0xC003, 0xC004, 0x4000.
- Start bit plus 3 data bits, idle 6000 cycles, then frame 0xF0 with parity 1. Required: reads return 0xA0F0, then 0x2000.
- 3-cycle low glitches on ps2c_i during a valid frame 0x5A. Required: read 0x805A, no err.
- Read strobe in the same cycle as the stop-bit push, with the FIFO holding 0x11; then sys_rst_i pulsed low mid-frame. Required: first read 0x8011, next read 0x80xx with the new byte. After reset, read 0x0000 and no stray push.
